cpu_bus_sequencer: RTL and testbench

- Owns the CPU-side system bus and divides the 21.47727 MHz master clock by 12 into CPU bus cycles.
- Issues the per-cycle advance pulse that steps the CPU core.
- Arbitrates the bus between the CPU core and an OAM DMA engine triggered by a CPU write to $4014.
- Sits between the CPU core and the address decoder (RAM/ROM/PPU/APU).

---
 rtl/cpu_bus_sequencer_pkg.sv | 24 ++
 rtl/cpu_bus_sequencer_if.sv | 32 +++
 rtl/cpu_bus_sequencer_phase_gen.sv | 42 ++++
 rtl/cpu_bus_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_bus_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nes_bus_pkg
// Purpose  : Shared types and constants for the CPU-side bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package nes_bus_pkg;

  // Owner/activity of the current CPU bus cycle
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } bus_state_t;

  localparam int          CPU_CLK_DIV   = 12;
  localparam logic [15:0] RESET_VECTOR  = 16'hFFFC;
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage
`default_nettype wire

// File: rtl/cpu_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_sequencer_if
// Purpose  : CPU-core and decoder-side signals of the bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_bus_sequencer_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic        cpu_step;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rw;
  logic [7:0]  bus_din;
  logic        dma_active;
  logic        cycle_odd;

  // Sequencer side: owns the bus toward the decoder
  modport master (
    input  cpu_addr, cpu_wdata, cpu_rw, bus_din,
    output cpu_step, cpu_rdata, bus_addr, bus_dout, bus_rw, dma_active, cycle_odd
  );

  // CPU core / decoder side
  modport slave (
    output cpu_addr, cpu_wdata, cpu_rw, bus_din,
    input  cpu_step, cpu_rdata, bus_addr, bus_dout, bus_rw, dma_active, cycle_odd
  );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_sequencer_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_gen
// Purpose  : Divides the master clock into CPU bus cycles; flags the first
//            and last master clock of each cycle and tracks cycle parity.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_phase_gen #(
  parameter int CLK_DIV = 12
) (
  input  logic clock,
  input  logic reset,
  output logic cycle_start_o,
  output logic cycle_end_o,
  output logic cycle_odd_o
);

  localparam int             PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] ph_q;
  logic            odd_q;

  // Free-running phase counter; parity flips as each bus cycle finishes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_q  <= '0;
      odd_q <= 1'b0;
    end else if (ph_q == PH_LAST) begin
      ph_q  <= '0;
      odd_q <= ~odd_q;
    end else begin
      ph_q  <= ph_q + PH_W'(1);
    end
  end

  assign cycle_start_o = (ph_q == '0);
  assign cycle_end_o   = (ph_q == PH_LAST);
  assign cycle_odd_o   = odd_q;

endmodule
`default_nettype wire

// File: rtl/cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_sequencer
// Purpose  : Paces the CPU core in bus cycles and arbitrates the system bus
//            between the CPU and the OAM DMA engine started by a $4014 write.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_sequencer #(
  parameter int          CLK_DIV       = nes_bus_pkg::CPU_CLK_DIV,
  parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR
) (
  input  logic                 clock,
  input  logic                 reset,
  cpu_bus_sequencer_if.master  bus
);
  import nes_bus_pkg::*;

  logic cycle_start, cycle_end, cycle_odd;

  cpu_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clock         (clock),
    .reset         (reset),
    .cycle_start_o (cycle_start),
    .cycle_end_o   (cycle_end),
    .cycle_odd_o   (cycle_odd)
  );

  bus_state_t  state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  latch_q, latch_d;
  logic [7:0]  rdata_q;
  logic [15:0] bus_addr_q;
  logic [7:0]  bus_dout_q;
  logic        bus_rw_q;
  logic        dma_q;

  // The halt decision needs the CPU's next direction, which is only visible
  // once the core has stepped, so it is taken at the start of that cycle.
  logic       halt_start;
  bus_state_t owner;
  assign halt_start = cycle_start && (state_q == IDLE) && pending_q && bus.cpu_rw;
  assign owner      = halt_start ? HALT : state_q;

  // Next-state logic: DMA trigger capture and arbitration sequencing
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    page_d    = page_q;
    idx_d     = idx_q;
    latch_d   = latch_q;
    if (halt_start) begin
      state_d = HALT;
    end
    if (cycle_end) begin
      case (state_q)
        IDLE: begin
          if (!bus.cpu_rw && (bus.cpu_addr == DMA_REG_ADDR)) begin
            page_d    = bus.cpu_wdata;
            pending_d = 1'b1;
          end
        end
        HALT: begin
          pending_d = 1'b0;
          state_d   = cycle_odd ? ALIGN : READ;
        end
        ALIGN: state_d = READ;
        READ: begin
          latch_d = bus.bus_din;
          state_d = WRITE;
        end
        WRITE: begin
          if (idx_q == 8'hFF) begin
            idx_d   = 8'h00;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 8'h01;
            state_d = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus source selection for the cycle about to start
  logic [15:0] sel_addr;
  logic [7:0]  sel_dout;
  logic        sel_rw;
  always_comb begin
    sel_addr = bus.cpu_addr;
    sel_dout = bus.cpu_wdata;
    sel_rw   = bus.cpu_rw;
    case (owner)
      HALT, ALIGN: sel_rw = 1'b1;
      READ: begin
        sel_addr = {page_q, idx_q};
        sel_dout = bus_dout_q;
        sel_rw   = 1'b1;
      end
      WRITE: begin
        sel_addr = OAM_DATA_ADDR;
        sel_dout = latch_q;
        sel_rw   = 1'b0;
      end
      default: ;
    endcase
  end

  // State, DMA bookkeeping and bus output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      latch_q    <= 8'h00;
      rdata_q    <= 8'h00;
      bus_addr_q <= RESET_VECTOR;
      bus_dout_q <= 8'h00;
      bus_rw_q   <= 1'b1;
      dma_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      latch_q   <= latch_d;
      if (cycle_start) begin
        bus_addr_q <= sel_addr;
        bus_dout_q <= sel_dout;
        bus_rw_q   <= sel_rw;
        dma_q      <= (owner != IDLE);
      end
      if (cycle_end) begin
        rdata_q <= bus.bus_din;
      end
    end
  end

  assign bus.cpu_step   = cycle_end && (state_q == IDLE);
  assign bus.cpu_rdata  = rdata_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_dout   = bus_dout_q;
  assign bus.bus_rw     = bus_rw_q;
  assign bus.dma_active = dma_q;
  assign bus.cycle_odd  = cycle_odd;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_sequencer
// Purpose  : Self-checking bench: CPU op lists are expanded into an expected
//            per-cycle bus trace and compared against the sequencer outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_sequencer;
  import nes_bus_pkg::*;

  localparam int MAXC  = 2048;
  localparam int MAXOP = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cpu_bus_sequencer_if bif();

  cpu_bus_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] op_addr [MAXOP];
  logic [7:0]  op_wd   [MAXOP];
  logic        op_rw   [MAXOP];
  int          nops;

  logic [15:0] e_addr [MAXC];
  logic        e_rw   [MAXC];
  logic [7:0]  e_dout [MAXC];
  logic        e_dma  [MAXC];
  logic        e_step [MAXC];
  int          dma_start;
  bit          dma_align;

  logic [7:0] key;
  int         ci;

  // Decoder model: read data is the low address byte scrambled by a key
  function automatic logic [7:0] dec_data(input logic [15:0] a);
    return a[7:0] ^ key;
  endfunction

  always @(negedge clock) bif.bus_din = dec_data(bif.bus_addr);

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void get_op(input int i, output logic [15:0] a, output logic [7:0] w, output logic r);
    if (i < nops) begin
      a = op_addr[i]; w = op_wd[i]; r = op_rw[i];
    end else begin
      a = 16'h8000; w = 8'h00; r = 1'b1;
    end
  endfunction

  task automatic present(input int i);
    logic [15:0] a; logic [7:0] w; logic r;
    get_op(i, a, w, r);
    bif.cpu_addr  = a;
    bif.cpu_wdata = w;
    bif.cpu_rw    = r;
  endtask

  function automatic void put(input int k, input logic [15:0] a, input logic r,
                              input logic [7:0] d, input logic dma, input logic st);
    if (k < MAXC) begin
      e_addr[k] = a; e_rw[k] = r; e_dout[k] = d; e_dma[k] = dma; e_step[k] = st;
    end
  endfunction

  // Expand the CPU op list into the expected sequence of bus cycles
  function automatic void build_model(input int ncyc);
    int k = 0;
    int i = 0;
    bit pend = 0;
    logic [7:0] pg = 8'h00;
    logic [15:0] a; logic [7:0] w; logic r;
    dma_start = -1;
    dma_align = 0;
    while (k < ncyc) begin
      get_op(i, a, w, r);
      if (pend && r) begin
        if (dma_start < 0) begin
          dma_start = k;
          dma_align = (k % 2) == 1;
        end
        put(k, a, 1'b1, 8'h00, 1'b1, 1'b0);
        pend = 0;
        if ((k % 2) == 1) begin
          k++;
          put(k, a, 1'b1, 8'h00, 1'b1, 1'b0);
        end
        k++;
        for (int j = 0; j < 256; j++) begin
          put(k, {pg, 8'(j)}, 1'b1, 8'h00, 1'b1, 1'b0); k++;
          put(k, 16'h2004, 1'b0, dec_data({pg, 8'(j)}), 1'b1, 1'b0); k++;
        end
      end else begin
        put(k, a, r, w, 1'b0, 1'b1);
        k++;
        if (!r && a == 16'h4014) begin
          pend = 1;
          pg   = w;
        end
        i++;
      end
    end
  endfunction

  task automatic check_reset_vals(input string pfx);
    check_value({pfx, "_addr"},  32'(bif.bus_addr),   32'hFFFC);
    check_value({pfx, "_rw"},    32'(bif.bus_rw),     32'h1);
    check_value({pfx, "_dout"},  32'(bif.bus_dout),   32'h0);
    check_value({pfx, "_dma"},   32'(bif.dma_active), 32'h0);
    check_value({pfx, "_odd"},   32'(bif.cycle_odd),  32'h0);
    check_value({pfx, "_step"},  32'(bif.cpu_step),   32'h0);
    check_value({pfx, "_rdata"}, 32'(bif.cpu_rdata),  32'h0);
  endtask

  // Reset, release, then follow the CPU through ncyc bus cycles
  task automatic run(input int ncyc, input int abort_pair);
    int abort_cycle;
    bit step_seen;
    int ph, k;
    build_model(ncyc);
    abort_cycle = -1;
    if (abort_pair >= 0 && dma_start >= 0)
      abort_cycle = dma_start + (dma_align ? 2 : 1) + 2 * abort_pair;
    reset = 1'b0;
    ci = 0;
    present(0);
    repeat (3) @(negedge clock);
    #1 check_reset_vals("rst");
    @(negedge clock) reset = 1'b1;
    step_seen = 0;
    for (int n = 1; n <= ncyc * 12; n++) begin
      @(posedge clock);
      if (step_seen) begin
        #1;
        ci++;
        present(ci);
      end
      @(negedge clock);
      ph = n % 12;
      k  = n / 12;
      if (k == abort_cycle && ph == 5) begin
        #2 reset = 1'b0;
        #1 check_reset_vals("midrst");
        return;
      end
      if (ph == 0 && k > 0)
        check_value("rdata", 32'(bif.cpu_rdata), 32'(dec_data(e_addr[k-1])));
      if (k < ncyc) begin
        if (ph == 6) begin
          check_value("bus_addr", 32'(bif.bus_addr),   32'(e_addr[k]));
          check_value("bus_rw",   32'(bif.bus_rw),     32'(e_rw[k]));
          if (!e_rw[k]) check_value("bus_dout", 32'(bif.bus_dout), 32'(e_dout[k]));
          check_value("dma",      32'(bif.dma_active), 32'(e_dma[k]));
          check_value("odd",      32'(bif.cycle_odd),  32'((k % 2) == 1));
        end
        check_value("step", 32'(bif.cpu_step), 32'((ph == 11) && e_step[k]));
        step_seen = (ph == 11) && bif.cpu_step;
      end
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [7:0] w, input logic r);
    op_addr[i] = a; op_wd[i] = w; op_rw[i] = r;
  endtask

  task automatic random_ops(input int n, input bit triggers);
    logic [15:0] a;
    nops = n;
    set_op(0, 16'hFFFC, 8'h00, 1'b1);
    for (int i = 1; i < n; i++) begin
      if (triggers && $urandom_range(0, 7) == 0) begin
        set_op(i, 16'h4014, 8'($urandom), 1'b0);
      end else begin
        a = 16'($urandom);
        if (a == 16'h4014) a = 16'h4015;
        set_op(i, a, 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    bif.cpu_addr  = 16'hFFFC;
    bif.cpu_wdata = 8'h00;
    bif.cpu_rw    = 1'b1;

    // Plain CPU traffic, no DMA
    key = 8'($urandom);
    random_ops(21, 0);
    run(24, -1);

    // Trigger on an odd cycle: HALT lands even, no ALIGN
    key = 8'($urandom);
    nops = 4;
    set_op(0, 16'hFFFC, 8'h00, 1'b1);
    set_op(1, 16'h4014, 8'h02, 1'b0);
    set_op(2, 16'h8005, 8'h00, 1'b1);
    set_op(3, 16'h8006, 8'h00, 1'b1);
    run(520, -1);

    // Trigger on an even cycle: HALT lands odd, ALIGN inserted
    key = 8'($urandom);
    nops = 5;
    set_op(0, 16'hFFFC, 8'h00, 1'b1);
    set_op(1, 16'h8000, 8'h00, 1'b1);
    set_op(2, 16'h4014, 8'h02, 1'b0);
    set_op(3, 16'h8005, 8'h00, 1'b1);
    set_op(4, 16'h8006, 8'h00, 1'b1);
    run(522, -1);

    // Two CPU writes after the trigger delay the halt
    key = 8'($urandom);
    nops = 6;
    set_op(0, 16'hFFFC, 8'h00, 1'b1);
    set_op(1, 16'h4014, 8'($urandom), 1'b0);
    set_op(2, 16'h01FD, 8'h12, 1'b0);
    set_op(3, 16'h01FC, 8'h34, 1'b0);
    set_op(4, 16'h8005, 8'h00, 1'b1);
    set_op(5, 16'h8006, 8'h00, 1'b1);
    run(522, -1);

    // Page $FF with raw low-byte data
    key = 8'h00;
    nops = 3;
    set_op(0, 16'hFFFC, 8'h00, 1'b1);
    set_op(1, 16'h4014, 8'hFF, 1'b0);
    set_op(2, 16'h8005, 8'h00, 1'b1);
    run(520, -1);

    // Reset asserted during DMA pair 100
    key = 8'($urandom);
    nops = 3;
    set_op(0, 16'hFFFC, 8'h00, 1'b1);
    set_op(1, 16'h4014, 8'($urandom), 1'b0);
    set_op(2, 16'h9000, 8'h00, 1'b1);
    run(600, 100);

    // Randomized traffic with occasional DMA triggers
    for (int r = 0; r < 2; r++) begin
      key = 8'($urandom);
      random_ops(30, 1);
      run(700, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
